// File: rtl/board_port_arbiter_pkg.sv
// rtl/board_port_arbiter_pkg.sv - shared types and constants for the board read-port arbiter
package board_port_arbiter_pkg;

  localparam int LOG_MAX_ADDR = 16;
  localparam int WORD_SIZE    = 32;
  localparam int READ_LATENCY = 2;

  typedef enum logic {
    OWNER_RENDER = 1'b0,
    OWNER_UPDATE = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEP      = 2'd1,
    WAIT_SWAP = 2'd2
  } sched_state_t;

  // One in-flight read: whether it is real and who gets the returned word.
  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
  } read_tag_t;

  function automatic read_tag_t make_tag(input logic render_gnt, input logic update_gnt);
    read_tag_t t;
    t.valid = render_gnt | update_gnt;
    t.owner = render_gnt ? OWNER_RENDER : OWNER_UPDATE;
    return t;
  endfunction

endpackage

// File: rtl/board_port_arbiter_if.sv
// rtl/board_port_arbiter_if.sv - shared board read port: requesters, grants, returns and BRAM side
interface board_port_arbiter_if import board_port_arbiter_pkg::*; #(
  parameter int ADDR_W = LOG_MAX_ADDR,
  parameter int DATA_W = WORD_SIZE
);
  logic              render_req_in;
  logic [ADDR_W-1:0] render_addr_in;
  logic              render_grant_out;
  logic [DATA_W-1:0] render_data_out;
  logic              render_valid_out;

  logic              update_req_in;
  logic [ADDR_W-1:0] update_addr_in;
  logic              update_grant_out;
  logic [DATA_W-1:0] update_data_out;
  logic              update_valid_out;

  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_data_in;

  // Arbiter side.
  modport slave (
    input  render_req_in, render_addr_in, update_req_in, update_addr_in, mem_data_in,
    output render_grant_out, render_data_out, render_valid_out,
    output update_grant_out, update_data_out, update_valid_out, mem_addr_out
  );

  // Requesters plus BRAM side.
  modport master (
    output render_req_in, render_addr_in, update_req_in, update_addr_in, mem_data_in,
    input  render_grant_out, render_data_out, render_valid_out,
    input  update_grant_out, update_data_out, update_valid_out, mem_addr_out
  );
endinterface

// File: rtl/board_port_arbiter_read_tag_pipe.sv
// rtl/board_port_arbiter_read_tag_pipe.sv - {valid, owner} delay line matching the BRAM read latency
module board_port_arbiter_read_tag_pipe import board_port_arbiter_pkg::*; #(
  parameter int DEPTH = READ_LATENCY + 1
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  read_tag_t tag_in,
  output read_tag_t tag_out
);

  read_tag_t [DEPTH-1:0] stage;

  // Shift one tag per cycle; reset flushes every in-flight read.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/board_port_arbiter.sv
// rtl/board_port_arbiter.sv - board BRAM read-port sharing and generation/frame sequencing
module board_port_arbiter #(
  parameter int LOG_MAX_ADDR = board_port_arbiter_pkg::LOG_MAX_ADDR,
  parameter int WORD_SIZE    = board_port_arbiter_pkg::WORD_SIZE,
  parameter int READ_LATENCY = board_port_arbiter_pkg::READ_LATENCY,
  parameter int OVR_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             frame_start_in,
  input  logic             run_in,
  input  logic             step_once_in,
  input  logic             step_done_in,
  output logic             step_start_out,
  output logic             buf_sel_out,
  output logic             busy_out,
  output logic [OVR_W-1:0] overrun_out,
  board_port_arbiter_if.slave port
);
  import board_port_arbiter_pkg::*;

  sched_state_t          state;
  logic                  render_grant;
  logic                  update_grant;
  logic [LOG_MAX_ADDR-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0]  rd_data;
  read_tag_t             tag_out;
  logic                  step_once_pending;
  logic                  pending_next;
  logic                  want_step;

  // Renderer always wins; the update engine only reads while a generation is being computed.
  assign render_grant = port.render_req_in;
  assign update_grant = port.update_req_in & ~port.render_req_in & (state == STEP);

  assign port.render_grant_out = render_grant;
  assign port.update_grant_out = update_grant;
  assign port.mem_addr_out     = mem_addr_q;

  // Register the granted address; with no grant the port idles on the last address.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_addr_q <= '0;
    end else if (render_grant) begin
      mem_addr_q <= port.render_addr_in;
    end else if (update_grant) begin
      mem_addr_q <= port.update_addr_in;
    end
  end

  board_port_arbiter_read_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .tag_in  (make_tag(render_grant, update_grant)),
    .tag_out (tag_out)
  );

  // Both consumers see the raw BRAM word; only the valid flag says whose it is.
  assign rd_data               = port.mem_data_in;
  assign port.render_data_out  = rd_data;
  assign port.update_data_out  = rd_data;
  assign port.render_valid_out = tag_out.valid & (tag_out.owner == OWNER_RENDER);
  assign port.update_valid_out = tag_out.valid & (tag_out.owner == OWNER_UPDATE);

  // A single-step request is only meaningful while paused; it waits for the next frame.
  assign pending_next = step_once_pending | (step_once_in & ~run_in);
  assign want_step    = run_in | pending_next;

  // Generation sequencer: the displayed buffer flips only at frame start after a finished step.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= IDLE;
      step_start_out    <= 1'b0;
      buf_sel_out       <= 1'b0;
      busy_out          <= 1'b0;
      overrun_out       <= '0;
      step_once_pending <= 1'b0;
    end else begin
      step_start_out    <= 1'b0;
      step_once_pending <= pending_next;
      case (state)
        IDLE: begin
          if (frame_start_in && want_step) begin
            state             <= STEP;
            busy_out          <= 1'b1;
            step_start_out    <= 1'b1;
            step_once_pending <= 1'b0;
          end
        end
        STEP: begin
          if (step_done_in) begin
            if (frame_start_in) begin
              buf_sel_out <= ~buf_sel_out;
              if (want_step) begin
                step_start_out    <= 1'b1;
                step_once_pending <= 1'b0;
              end else begin
                state    <= IDLE;
                busy_out <= 1'b0;
              end
            end else begin
              state <= WAIT_SWAP;
            end
          end else if (frame_start_in && (overrun_out != '1)) begin
            overrun_out <= overrun_out + 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_start_in) begin
            buf_sel_out <= ~buf_sel_out;
            if (want_step) begin
              state             <= STEP;
              step_start_out    <= 1'b1;
              step_once_pending <= 1'b0;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_port_arbiter.sv
// tb/tb_board_port_arbiter.sv - randomized self-checking bench for board_port_arbiter
module tb_board_port_arbiter;
  import board_port_arbiter_pkg::*;

  localparam int AW = LOG_MAX_ADDR;
  localparam int DW = WORD_SIZE;
  localparam int RL = READ_LATENCY;
  localparam int OW = 8;
  localparam int OVR_MAX = (1 << OW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          run_in = 1'b0;
  logic          step_once_in = 1'b0;
  logic          step_done_in = 1'b0;
  logic          step_start_out;
  logic          buf_sel_out;
  logic          busy_out;
  logic [OW-1:0] overrun_out;

  board_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  board_port_arbiter #(
    .LOG_MAX_ADDR(AW), .WORD_SIZE(DW), .READ_LATENCY(RL), .OVR_W(OW)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .frame_start_in(frame_start_in),
    .run_in        (run_in),
    .step_once_in  (step_once_in),
    .step_done_in  (step_done_in),
    .step_start_out(step_start_out),
    .buf_sel_out   (buf_sel_out),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out),
    .port          (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A3C_96E1;
  endfunction

  // BRAM: RL register stages from the registered address to the data output.
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk_in) begin
    rd_pipe[0] <= bram_word(bus.mem_addr_out);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_data_in = rd_pipe[RL-1];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 paused, 1 computing, 2 finished and waiting for frame.
  int            cyc = 0;
  int            m_phase;
  bit            m_buf, m_pend, m_start;
  int            m_ovr;
  logic [AW-1:0] m_addr;
  bit            exp_rv [8];
  bit            exp_uv [8];
  logic [DW-1:0] exp_d [8];
  bit            upd_taken;
  int            frame_cnt, done_cnt;

  task automatic model_reset();
    m_phase = 0; m_buf = 0; m_pend = 0; m_start = 0; m_ovr = 0; m_addr = '0;
    upd_taken = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin exp_rv[i] = 0; exp_uv[i] = 0; exp_d[i] = '0; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr_out), 64'(0));
    chk({tag, "_render_valid"}, 64'(bus.render_valid_out), 64'(0));
    chk({tag, "_update_valid"}, 64'(bus.update_valid_out), 64'(0));
    chk({tag, "_step_start"}, 64'(step_start_out), 64'(0));
    chk({tag, "_buf_sel"}, 64'(buf_sel_out), 64'(0));
    chk({tag, "_busy"}, 64'(busy_out), 64'(0));
    chk({tag, "_overrun"}, 64'(overrun_out), 64'(0));
  endtask

  task automatic run_cycle();
    int slot, s2;
    bit eg_r, eg_u, pend_eff, want, go;
    logic [AW-1:0] a;
    @(negedge clk_in);
    slot = cyc % 8;
    eg_r = bus.render_req_in;
    eg_u = bus.update_req_in && !bus.render_req_in && (m_phase == 1);
    chk("render_grant", 64'(bus.render_grant_out), 64'(eg_r));
    chk("update_grant", 64'(bus.update_grant_out), 64'(eg_u));
    chk("mem_addr", 64'(bus.mem_addr_out), 64'(m_addr));
    chk("render_valid", 64'(bus.render_valid_out), 64'(exp_rv[slot]));
    chk("update_valid", 64'(bus.update_valid_out), 64'(exp_uv[slot]));
    if (exp_rv[slot] || exp_uv[slot]) begin
      chk("render_data", 64'(bus.render_data_out), 64'(exp_d[slot]));
      chk("update_data", 64'(bus.update_data_out), 64'(exp_d[slot]));
    end
    chk("step_start", 64'(step_start_out), 64'(m_start));
    chk("buf_sel", 64'(buf_sel_out), 64'(m_buf));
    chk("busy", 64'(busy_out), 64'(m_phase != 0));
    chk("overrun", 64'(overrun_out), 64'(m_ovr));
    exp_rv[slot] = 0;
    exp_uv[slot] = 0;
    // A grant now returns data 1 + RL cycles later.
    if (eg_r || eg_u) begin
      s2 = (cyc + 1 + RL) % 8;
      a = eg_r ? bus.render_addr_in : bus.update_addr_in;
      exp_rv[s2] = eg_r;
      exp_uv[s2] = eg_u;
      exp_d[s2] = bram_word(a);
      m_addr = a;
    end
    upd_taken = eg_u;
    // Generation rules.
    pend_eff = m_pend || (step_once_in && !run_in);
    want = run_in || pend_eff;
    go = 0;
    m_start = 0;
    if (m_phase == 0) begin
      go = frame_start_in && want;
    end else if (m_phase == 1) begin
      if (step_done_in && frame_start_in) begin
        m_buf = !m_buf;
        if (want) go = 1; else m_phase = 0;
      end else if (step_done_in) begin
        m_phase = 2;
      end else if (frame_start_in) begin
        m_ovr = (m_ovr < OVR_MAX) ? m_ovr + 1 : OVR_MAX;
      end
    end else begin
      if (frame_start_in) begin
        m_buf = !m_buf;
        if (want) go = 1; else m_phase = 0;
      end
    end
    if (go) begin m_phase = 1; m_start = 1; m_pend = 0; end
    else m_pend = pend_eff;
    cyc++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_idle_inputs();
    frame_start_in = 0; step_once_in = 0; step_done_in = 0;
    bus.render_req_in = 0; bus.update_req_in = 0;
  endtask

  task automatic gen_random();
    frame_start_in = 0;
    step_done_in = 0;
    step_once_in = 0;
    if (frame_cnt > 0) frame_cnt--;
    if (frame_cnt == 0) begin
      frame_start_in = 1;
      frame_cnt = $urandom_range(40, 90);
    end
    if (m_start) begin
      done_cnt = $urandom_range(5, 150);
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) step_done_in = 1;
    end else if (m_phase != 1 && $urandom_range(0, 63) == 0) begin
      step_done_in = 1;
    end
    if (step_done_in && !frame_start_in && frame_cnt < 15 && $urandom_range(0, 1) == 1) begin
      frame_start_in = 1;
      frame_cnt = $urandom_range(40, 90);
    end
    if ($urandom_range(0, 299) == 0) run_in = !run_in;
    if (!frame_start_in && $urandom_range(0, 99) == 0) step_once_in = 1;
    bus.render_req_in = ($urandom_range(0, 2) == 0);
    bus.render_addr_in = AW'($urandom());
    if (!bus.update_req_in || upd_taken) begin
      bus.update_req_in = ($urandom_range(0, 1) == 1);
      bus.update_addr_in = AW'($urandom());
    end
  endtask

  initial begin
    int k;
    bus.render_req_in = 0; bus.render_addr_in = '0;
    bus.update_req_in = 0; bus.update_addr_in = '0;
    model_reset();
    @(negedge clk_in);
    check_reset_outputs("por");
    @(posedge clk_in);
    #1;
    rst_n_in = 1;

    // Priority: both request for 4 cycles inside a step, then render drops.
    run_in = 1; frame_start_in = 1;
    run_cycle();
    frame_start_in = 0;
    run_cycle();
    run_cycle();
    bus.update_req_in = 1; bus.update_addr_in = 16'h0BEE;
    for (int i = 0; i < 4; i++) begin
      bus.render_req_in = 1; bus.render_addr_in = AW'(16'h0100 + i);
      run_cycle();
    end
    bus.render_req_in = 0;
    k = 0;
    while (!upd_taken && k < 4) begin run_cycle(); k++; end
    if (!upd_taken) chk("update_granted_after_render", 64'(0), 64'(1));
    bus.update_req_in = 0;
    for (int i = 0; i < 8; i++) run_cycle();
    step_done_in = 1;
    run_cycle();
    step_done_in = 0;
    for (int i = 0; i < 3; i++) run_cycle();
    frame_start_in = 1;
    run_cycle();
    frame_start_in = 0;

    // Randomized traffic and scheduling.
    run_in = 0;
    frame_cnt = 30;
    done_cnt = (m_phase == 1) ? 20 : 0;
    for (int i = 0; i < 6000; i++) begin
      gen_random();
      run_cycle();
    end

    // Done and frame start in the same cycle while free-running.
    set_idle_inputs();
    run_in = 1;
    k = 0;
    while (m_phase != 1 && k < 400) begin
      frame_start_in = (k % 10 == 0);
      run_cycle();
      k++;
    end
    frame_start_in = 0;
    if (m_phase != 1) chk("reach_step", 64'(0), 64'(1));
    run_cycle();
    frame_start_in = 1; step_done_in = 1;
    run_cycle();
    frame_start_in = 0; step_done_in = 0;
    run_cycle();
    run_cycle();

    // Late step on every frame until the overrun counter saturates.
    for (int f = 0; f < 280; f++) begin
      for (int j = 0; j < 3; j++) begin
        frame_start_in = (j == 0);
        bus.render_req_in = ($urandom_range(0, 1) == 1);
        bus.render_addr_in = AW'($urandom());
        if (!bus.update_req_in || upd_taken) begin
          bus.update_req_in = ($urandom_range(0, 1) == 1);
          bus.update_addr_in = AW'($urandom());
        end
        run_cycle();
      end
    end

    // Asynchronous reset mid-step with three renderer reads in flight.
    frame_start_in = 0; bus.update_req_in = 0;
    for (int i = 0; i < 3; i++) begin
      bus.render_req_in = 1; bus.render_addr_in = AW'(16'h2000 + i);
      run_cycle();
    end
    set_idle_inputs();
    #2;
    rst_n_in = 0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk_in);
    check_reset_outputs("rst_held");
    @(posedge clk_in);
    #1;
    rst_n_in = 1;
    model_reset();
    run_in = 0;
    for (int i = 0; i < 12; i++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_port_arbiter.md
Name: board_port_arbiter

Overview:
- Owns the single read port of the board memory.
- Shares that port between the renderer's cell fetch and the generation-update engine. The renderer has fixed priority; the update engine gets leftover cycles.
- Sequences generations against the display frame: it starts an update step, waits for completion, and flips the double-buffer select only at frame start, so a half-computed board is never displayed.
- Sits between the xvga timing / render fetch path, the update engine, and the board BRAM.

Parameters:
- LOG_MAX_ADDR, 16, board memory address width.
- WORD_SIZE, 32, board memory word width.
- READ_LATENCY, 2, BRAM cycles from registered address to valid data (1..4).
- OVR_W, 8, overrun counter width.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- frame_start_in  in  1  one-cycle pulse at vblank onset
- run_in  in  1  level; free-run one generation per frame
- step_once_in  in  1  pulse; run exactly one generation while paused
- render_req_in  in  1  renderer read request
- render_addr_in  in  LOG_MAX_ADDR  renderer read address
- update_req_in  in  1  update engine read request
- update_addr_in  in  LOG_MAX_ADDR  update engine read address
- render_grant_out  out  1  renderer request accepted this cycle (combinational)
- update_grant_out  out  1  update request accepted this cycle (combinational)
- mem_addr_out  out  LOG_MAX_ADDR  registered BRAM address
- mem_data_in  in  WORD_SIZE  BRAM read data
- render_data_out  out  WORD_SIZE  returned data to renderer
- render_valid_out  out  1  render_data_out valid
- update_data_out  out  WORD_SIZE  returned data to update engine
- update_valid_out  out  1  update_data_out valid
- step_start_out  out  1  one-cycle pulse; update engine begins a generation
- step_done_in  in  1  pulse; update engine finished the generation
- buf_sel_out  out  1  index of the buffer being displayed; the update engine writes to ~buf_sel_out
- busy_out  out  1  state is STEP or WAIT_SWAP
- overrun_out  out  OVR_W  saturating count of frames where the step was late

Behaviour:
Reset:
- Asserting rst_n_in low clears every register immediately, whatever the state (including mid-read and mid-step).
- Outputs go to 0: mem_addr_out, valid flags, step_start_out, buf_sel_out, busy_out, overrun_out.
- State goes to IDLE and the in-flight tag pipeline is flushed.

Arbitration:
- render_grant_out = render_req_in.
- update_grant_out = update_req_in & ~render_req_in & (state==STEP).
- On any grant in cycle t, mem_addr_out takes the granted address at edge t+1. Otherwise it holds its value and no read is issued.
- A tag shift register of depth READ_LATENCY+1 carries {valid, owner}. The matching valid output is high exactly at cycle t+1+READ_LATENCY, for one cycle per grant.
- render_data_out and update_data_out both carry mem_data_in. Consumers use only the valid flags.
- The arbiter is fully pipelined: one grant per cycle, back-to-back, with no bubbles.
- A refused update request holds its request and address until granted. No request is ever dropped.

State machine (IDLE, STEP, WAIT_SWAP):
- IDLE:
  - If frame_start_in & (run_in | step_once_pending), go to STEP and pulse step_start_out the next cycle.
  - step_once_in sets step_once_pending; entering STEP clears it.
- STEP:
  - step_done_in goes to WAIT_SWAP.
  - frame_start_in while still in STEP increments overrun_out (saturating at all-ones). buf_sel_out does not toggle; the old frame is re-displayed.
  - If step_done_in and frame_start_in arrive in the same cycle, the done takes effect first. buf_sel_out toggles, with no overrun, and the next-step rule of WAIT_SWAP applies in that same cycle.
- WAIT_SWAP:
  - On frame_start_in, toggle buf_sel_out.
  - Then go to STEP (pulsing step_start_out) if run_in | step_once_pending; otherwise go to IDLE.
- Dropping run_in mid-step never aborts the step. The FSM finishes it and swaps before going idle.
- step_done_in outside STEP is ignored.
- step_once_in while run_in is high is ignored.

Decomposition:
- Shared package (common.svh):
  - arb_owner_t enum {OWNER_RENDER, OWNER_UPDATE}
  - sched_state_t enum {IDLE, STEP, WAIT_SWAP}
  - constant READ_LATENCY
  - existing LOG_MAX_ADDR and WORD_SIZE
- Sub-module read_tag_pipe: a parameterised {valid, owner} delay line of depth READ_LATENCY+1, reused by any future port sharer.

Test Plan:
- Reset mid-operation: rst_n_in low in STEP with 3 reads in flight -> all outputs 0 asynchronously; no valid pulses after release.
- Priority: both requests held 4 cycles, then render drops -> update_grant_out 0 for 4 cycles then 1. With READ_LATENCY=2, render_valid_out is high at cycles 3–6 and update_valid_out from cycle 7, carrying BRAM contents at the requested addresses.
- Free run: run_in=1, step_done_in 1000 cycles after each step_start_out, frame_start_in every 5000 cycles -> buf_sel_out toggles every frame; overrun_out stays 0.
- Overrun: step_done_in delayed 7000 cycles -> overrun_out=1; buf_sel_out toggles one frame late.
- Single step: run_in=0, step_once_in pulse -> exactly one step_start_out at the next frame_start_in. One toggle follows at the frame after done, then IDLE (busy_out=0).
- Simultaneous step_done_in and frame_start_in with run_in=1 -> toggle, no overrun, step_start_out pulses the next cycle.
